// File: rtl/multi_cycle_ctrl.sv
// ============================================================================
// multi_cycle_ctrl : FETCH/DECODE/EXEC/MEM/WB control FSM for a multi-cycle
//                    MIPS-style datapath, with a retired-instruction counter.
// Revision 1.0
// ============================================================================
`default_nettype none

module multi_cycle_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        ZF,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_s,
  output logic        IR_write,
  output logic        PC_write,
  output logic [1:0]  PC_s,
  output logic [1:0]  w_r_s,
  output logic [1:0]  w_r_data_s,
  output logic        imm_s,
  output logic        rt_imm_s,
  output logic [2:0]  ALU_OP,
  output logic        WriteReg,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    C_R   = 3'd0,
    C_I1  = 3'd1,
    C_LW  = 3'd2,
    C_SW  = 3'd3,
    C_BR  = 3'd4,
    C_J   = 3'd5,
    C_JAL = 3'd6,
    C_ILL = 3'd7
  } cls_t;

  localparam logic [2:0] ALU_ADD = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b101;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b110;
  localparam logic [2:0] ALU_SLL = 3'b111;

  state_t      state_q, state_d;
  cls_t        cls_q, cls_d, dec_cls;
  logic [2:0]  alu_q, alu_d, dec_alu;
  logic        imm_s_q, imm_s_d, dec_imm_s;
  logic        jr_q, jr_d;
  logic        op0_q, op0_d;
  logic [15:0] retired_q, retired_d;
  logic        retire;

  // Live decode of the instruction word; only meaningful while in DECODE.
  always_comb begin
    dec_cls   = C_ILL;
    dec_alu   = ALU_AND;
    dec_imm_s = 1'b0;
    casez (opcode)
      6'b000000: dec_cls = C_R;
      6'b001???: dec_cls = C_I1;
      6'b100011: dec_cls = C_LW;
      6'b101011: dec_cls = C_SW;
      6'b00010?: dec_cls = C_BR;
      6'b000010: dec_cls = C_J;
      6'b000011: dec_cls = C_JAL;
      default:   dec_cls = C_ILL;
    endcase
    case (dec_cls)
      C_R: begin
        casez (funct)
          6'b100000: dec_alu = ALU_ADD;
          6'b100010: dec_alu = ALU_SUB;
          6'b1001??: dec_alu = {1'b0, funct[1:0]};
          6'b101011: dec_alu = ALU_SLT;
          6'b000100: dec_alu = ALU_SLL;
          default:   dec_alu = ALU_AND;
        endcase
      end
      C_I1: begin
        case (opcode[2:0])
          3'b000: begin dec_alu = ALU_ADD; dec_imm_s = 1'b1; end
          3'b100: dec_alu = ALU_AND;
          3'b101: dec_alu = ALU_OR;
          3'b110: dec_alu = ALU_XOR;
          3'b011: dec_alu = ALU_SLT;
          default: dec_alu = ALU_AND;
        endcase
      end
      C_LW, C_SW: begin dec_alu = ALU_ADD; dec_imm_s = 1'b1; end
      C_BR:       begin dec_alu = ALU_SUB; dec_imm_s = 1'b1; end
      default:    dec_alu = ALU_AND;
    endcase
  end

  // Decoded controls are frozen at DECODE so later IR-bus changes are harmless.
  always_comb begin
    cls_d   = cls_q;
    alu_d   = alu_q;
    imm_s_d = imm_s_q;
    jr_d    = jr_q;
    op0_d   = op0_q;
    if (state_q == S_DECODE) begin
      cls_d   = dec_cls;
      alu_d   = dec_alu;
      imm_s_d = dec_imm_s;
      jr_d    = (funct == 6'b001000);
      op0_d   = opcode[0];
    end
  end

  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr_s = 1'b0;
    IR_write   = 1'b0;
    PC_write   = 1'b0;
    PC_s       = 2'b00;
    w_r_s      = 2'b00;
    w_r_data_s = 2'b00;
    imm_s      = 1'b0;
    rt_imm_s   = 1'b0;
    ALU_OP     = 3'b000;
    WriteReg   = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          IR_write = 1'b1;
          PC_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        case (dec_cls)
          C_ILL: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
          C_J, C_JAL: begin
            PC_write = 1'b1;
            PC_s     = 2'b11;
            if (dec_cls == C_JAL) begin
              WriteReg   = 1'b1;
              w_r_s      = 2'b10;
              w_r_data_s = 2'b10;
            end
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        ALU_OP = alu_q;
        imm_s  = imm_s_q;
        case (cls_q)
          C_R: begin
            if (jr_q) begin
              PC_write = 1'b1;
              PC_s     = 2'b01;
              retire   = 1'b1;
              state_d  = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end
          C_I1: begin
            rt_imm_s = 1'b1;
            state_d  = S_WB;
          end
          C_LW, C_SW: begin
            rt_imm_s = 1'b1;
            state_d  = S_MEM;
          end
          C_BR: begin
            PC_write = ZF ^ op0_q;
            PC_s     = 2'b10;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_req    = 1'b1;
        mem_addr_s = 1'b1;
        mem_we     = (cls_q == C_SW);
        rt_imm_s   = 1'b1;
        imm_s      = 1'b1;
        ALU_OP     = ALU_ADD;
        if (mem_ack) begin
          if (cls_q == C_SW) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        WriteReg = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
        case (cls_q)
          C_R:  ALU_OP = alu_q;
          C_I1: begin
            w_r_s    = 2'b01;
            rt_imm_s = 1'b1;
            imm_s    = imm_s_q;
            ALU_OP   = alu_q;
          end
          C_LW: begin
            w_r_s      = 2'b01;
            w_r_data_s = 2'b01;
          end
          default: ;
        endcase
      end
      default: state_d = S_FETCH;
    endcase

    // Outputs are silenced for the whole reset assertion, not just at an edge.
    if (!rst_n) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr_s = 1'b0;
      IR_write   = 1'b0;
      PC_write   = 1'b0;
      PC_s       = 2'b00;
      w_r_s      = 2'b00;
      w_r_data_s = 2'b00;
      imm_s      = 1'b0;
      rt_imm_s   = 1'b0;
      ALU_OP     = 3'b000;
      WriteReg   = 1'b0;
      illegal    = 1'b0;
    end
  end

  always_comb begin
    retired_d = retired_q;
    if (retire) retired_d = retired_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      retired_q <= 16'd0;
      cls_q     <= C_ILL;
      alu_q     <= 3'b000;
      imm_s_q   <= 1'b0;
      jr_q      <= 1'b0;
      op0_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
      cls_q     <= cls_d;
      alu_q     <= alu_d;
      imm_s_q   <= imm_s_d;
      jr_q      <= jr_d;
      op0_q     <= op0_d;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_multi_cycle_ctrl.sv
// ============================================================================
// tb_multi_cycle_ctrl : randomized instruction-level bench for multi_cycle_ctrl.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_multi_cycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic [5:0]  funct = 6'd0;
  logic        ZF = 1'b0;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_we, mem_addr_s, IR_write, PC_write;
  logic [1:0]  PC_s, w_r_s, w_r_data_s;
  logic        imm_s, rt_imm_s, WriteReg, illegal;
  logic [2:0]  ALU_OP, state;
  logic [15:0] retired;

  int          total = 0;
  int          bad = 0;
  logic [15:0] model_ret = 16'd0;

  always #5 clk = ~clk;

  multi_cycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .ZF(ZF),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_s(mem_addr_s), .IR_write(IR_write), .PC_write(PC_write),
    .PC_s(PC_s), .w_r_s(w_r_s), .w_r_data_s(w_r_data_s), .imm_s(imm_s),
    .rt_imm_s(rt_imm_s), .ALU_OP(ALU_OP), .WriteReg(WriteReg),
    .state(state), .illegal(illegal), .retired(retired)
  );

  typedef struct {
    logic        ack;
    logic        zf;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [20:0] exp;
  } rec_t;

  wire [20:0] act_vec = {state, mem_req, mem_we, mem_addr_s, IR_write, PC_write,
                         PC_s, w_r_s, w_r_data_s, imm_s, rt_imm_s, ALU_OP,
                         WriteReg, illegal};

  function automatic logic [20:0] mk(
    input logic [2:0] st, input logic mreq, input logic mwe, input logic maddr,
    input logic irw, input logic pcw, input logic [1:0] pcs, input logic [1:0] wrs,
    input logic [1:0] wrds, input logic imm, input logic rti, input logic [2:0] alu,
    input logic wreg, input logic ill);
    return {st, mreq, mwe, maddr, irw, pcw, pcs, wrs, wrds, imm, rti, alu, wreg, ill};
  endfunction

  // Instruction classes: 0 R, 1 I-type ALU, 2 lw, 3 sw, 4 branch, 5 j, 6 jal, 7 illegal
  function automatic int ref_class(input logic [5:0] op);
    if (op == 6'b000000) return 0;
    if (op[5:3] == 3'b001) return 1;
    if (op == 6'b100011) return 2;
    if (op == 6'b101011) return 3;
    if (op == 6'b000100 || op == 6'b000101) return 4;
    if (op == 6'b000010) return 5;
    if (op == 6'b000011) return 6;
    return 7;
  endfunction

  function automatic logic [2:0] ref_r_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b100;  // add
      6'b100010: return 3'b101;  // sub
      6'b100100: return 3'b000;  // and
      6'b100101: return 3'b001;  // or
      6'b100110: return 3'b010;  // xor
      6'b100111: return 3'b011;  // nor
      6'b101011: return 3'b110;  // slt
      6'b000100: return 3'b111;  // sllv
      default:   return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] ref_i_alu(input logic [5:0] op);
    case (op)
      6'b001000: return 3'b100;  // addi
      6'b001100: return 3'b000;  // andi
      6'b001101: return 3'b001;  // ori
      6'b001110: return 3'b010;  // xori
      6'b001011: return 3'b110;  // sltiu
      default:   return 3'b000;
    endcase
  endfunction

  // Runs one instruction: builds its expected cycle list, then drives and checks
  // it. zf_mode<0 randomizes ZF; stop_after>=0 aborts after that many cycles.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int fd, input int md, input int zf_mode,
                           input int stop_after, input string tag);
    rec_t       q[$];
    rec_t       r;
    int         cls = ref_class(op);
    logic [2:0] ra = ref_r_alu(fn);
    logic [2:0] ia = ref_i_alu(op);
    logic       iimm = (op == 6'b001000);
    logic       z;
    int         n;
    for (int i = 0; i <= fd; i++) begin
      r.ack = (i == fd); r.zf = 1'($urandom); r.op = 6'($urandom); r.fn = 6'($urandom);
      r.exp = mk(3'd0, 1, 0, 0, r.ack, r.ack, 2'b00, 2'b00, 2'b00, 0, 0, 3'b000, 0, 0);
      q.push_back(r);
    end
    r.ack = 1'($urandom); r.zf = 1'($urandom); r.op = op; r.fn = fn;
    case (cls)
      5: r.exp = mk(3'd1, 0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 0, 0, 3'b000, 0, 0);
      6: r.exp = mk(3'd1, 0, 0, 0, 0, 1, 2'b11, 2'b10, 2'b10, 0, 0, 3'b000, 1, 0);
      7: r.exp = mk(3'd1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 3'b000, 0, 1);
      default: r.exp = mk(3'd1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 3'b000, 0, 0);
    endcase
    q.push_back(r);
    if (cls <= 4) begin
      z = (zf_mode < 0) ? 1'($urandom) : 1'(zf_mode);
      r.ack = 1'($urandom); r.zf = z; r.op = 6'($urandom); r.fn = 6'($urandom);
      case (cls)
        0: r.exp = (fn == 6'b001000) ?
             mk(3'd2, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 0, 0, ra, 0, 0) :
             mk(3'd2, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, ra, 0, 0);
        1: r.exp = mk(3'd2, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, iimm, 1, ia, 0, 0);
        2, 3: r.exp = mk(3'd2, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 1, 3'b100, 0, 0);
        default: r.exp = mk(3'd2, 0, 0, 0, 0, z ^ op[0], 2'b10, 2'b00, 2'b00, 1, 0,
                            3'b101, 0, 0);
      endcase
      q.push_back(r);
    end
    if (cls == 2 || cls == 3) begin
      for (int i = 0; i <= md; i++) begin
        r.ack = (i == md); r.zf = 1'($urandom); r.op = 6'($urandom); r.fn = 6'($urandom);
        r.exp = mk(3'd3, 1, (cls == 3), 1, 0, 0, 2'b00, 2'b00, 2'b00, 1, 1, 3'b100, 0, 0);
        q.push_back(r);
      end
    end
    if (cls == 1 || cls == 2 || (cls == 0 && fn != 6'b001000)) begin
      r.ack = 1'($urandom); r.zf = 1'($urandom); r.op = 6'($urandom); r.fn = 6'($urandom);
      case (cls)
        0: r.exp = mk(3'd4, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, ra, 1, 0);
        1: r.exp = mk(3'd4, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, iimm, 1, ia, 1, 0);
        default: r.exp = mk(3'd4, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, 0, 3'b000, 1, 0);
      endcase
      q.push_back(r);
    end
    n = (stop_after >= 0 && stop_after < q.size()) ? stop_after : q.size();
    for (int i = 0; i < n; i++) begin
      mem_ack = q[i].ack; ZF = q[i].zf; opcode = q[i].op; funct = q[i].fn;
      @(negedge clk);
      total++;
      if (act_vec !== q[i].exp) begin
        bad++;
        $display("FAIL %s cyc%0d outputs: got %h want %h", tag, i, act_vec, q[i].exp);
      end
      total++;
      if (retired !== model_ret) begin
        bad++;
        $display("FAIL %s cyc%0d retired: got %h want %h", tag, i, retired, model_ret);
      end
      @(posedge clk); #1;
    end
    if (n == q.size() && cls != 7) model_ret = model_ret + 16'd1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (act_vec !== 21'd0) begin
      bad++; $display("FAIL reset_outputs: got %h want %h", act_vec, 21'd0);
    end
    total++;
    if (retired !== 16'd0) begin
      bad++; $display("FAIL reset_retired: got %h want 0000", retired);
    end
    rst_n = 1'b1; mem_ack = 1'b0;
    #1;
    total++;
    if (act_vec !== mk(3'd0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 3'b000, 0, 0)) begin
      bad++; $display("FAIL reset_release_fetch: got %h", act_vec);
    end
    model_ret = 16'd0;
  endtask

  task automatic test_add();
    run_instr(6'b000000, 6'b100000, 0, 0, -1, -1, "add");
    run_instr(6'b000000, 6'b100000, 1, 0, -1, -1, "add_fd1");
  endtask

  task automatic test_lw_delay();
    run_instr(6'b100011, 6'($urandom), 0, 3, -1, -1, "lw_d3");
    run_instr(6'b101011, 6'($urandom), 0, 2, -1, -1, "sw_d2");
  endtask

  task automatic test_branch();
    run_instr(6'b000100, 6'($urandom), 0, 0, 1, -1, "beq_z1");
    run_instr(6'b000101, 6'($urandom), 0, 0, 1, -1, "bne_z1");
    run_instr(6'b000100, 6'($urandom), 0, 0, 0, -1, "beq_z0");
    run_instr(6'b000101, 6'($urandom), 0, 0, 0, -1, "bne_z0");
  endtask

  task automatic test_jumps();
    run_instr(6'b000011, 6'($urandom), 0, 0, -1, -1, "jal");
    run_instr(6'b000010, 6'($urandom), 0, 0, -1, -1, "j");
    run_instr(6'b000000, 6'b001000, 0, 0, -1, -1, "jr");
  endtask

  task automatic test_illegal();
    run_instr(6'b111111, 6'($urandom), 0, 0, -1, -1, "ill_3f");
    run_instr(6'b010000, 6'($urandom), 1, 0, -1, -1, "ill_10");
    run_instr(6'b000001, 6'($urandom), 0, 0, -1, -1, "ill_01");
  endtask

  task automatic test_random();
    logic [5:0] ops[10] = '{6'b000000, 6'b001000, 6'b100011, 6'b101011, 6'b000100,
                            6'b000101, 6'b000010, 6'b000011, 6'b001000, 6'b110001};
    logic [5:0] fns[9]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                            6'b100111, 6'b101011, 6'b000100, 6'b001000};
    logic [5:0] op, fn;
    for (int k = 0; k < 80; k++) begin
      op = ops[$urandom_range(0, 9)];
      if (op == 6'b001000) op = {3'b001, 3'($urandom)};
      fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fns[$urandom_range(0, 8)];
      run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 3), -1, -1, "rand");
    end
  endtask

  task automatic test_sw_reset();
    run_instr(6'b101011, 6'd0, 0, 5, -1, 4, "sw_abort");
    mem_ack = 1'b0;
    #2;
    total++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || state !== 3'd3) begin
      bad++;
      $display("FAIL sw_pre_reset: got req=%b we=%b st=%0d want 1 1 3", mem_req, mem_we, state);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (act_vec !== 21'd0 || retired !== 16'd0) begin
      bad++;
      $display("FAIL sw_mid_reset: got %h/%h want 000000/0000", act_vec, retired);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_ret = 16'd0;
    run_instr(6'b000000, 6'b100000, 0, 0, -1, -1, "add_after_rst");
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 4; k++) run_instr(6'b000010, 6'($urandom), 0, 0, -1, -1, "j_cnt");
    force dut.retired_q = 16'hFFFD;
    #1;
    release dut.retired_q;
    model_ret = 16'hFFFD;
    for (int k = 0; k < 4; k++) run_instr(6'b000010, 6'($urandom), 0, 0, -1, -1, "j_wrap");
    total++;
    if (retired !== 16'h0001) begin
      bad++; $display("FAIL wrap_final: got %h want 0001", retired);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_delay();
    test_branch();
    test_jumps();
    test_illegal();
    test_random();
    test_sw_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 clk  in  1  sole clock; all state changes on rising edge.
REQ-002 rst_n  in  1  asynchronous active-low reset.
REQ-003 opcode  in  6  IR[31:26], valid from DECODE onward.
REQ-004 funct  in  6  IR[5:0].
REQ-005 ZF  in  1  ALU zero flag, combinational from current ALU_OP/operands.
REQ-006 mem_ack  in  1  shared memory completion; sampled only while mem_req=1.
REQ-007 mem_req  out  1  memory access request, held until mem_ack.
REQ-008 mem_we  out  1  write strobe, qualifies mem_req.
REQ-009 mem_addr_s  out  1  0=PC, 1=ALU result.
REQ-010 IR_write, PC_write  out  1 each  load strobes.
REQ-011 PC_s  out  2  00=PC+4, 01=rs (jr), 10=branch target, 11=jump target.
REQ-012 w_r_s  out  2  00=rd, 01=rt, 10=$31.
REQ-013 w_r_data_s  out  2  00=ALU, 01=memory, 10=PC.
REQ-014 imm_s  out  1  1=sign-extend, 0=zero-extend.
REQ-015 rt_imm_s  out  1  0=rt, 1=immediate.
REQ-016 ALU_OP  out  3  100 add, 101 sub, 000 and, 001 or, 010 xor, 011 nor, 110 slt, 111 sllv.
REQ-017 WriteReg  out  1  register-file write enable.
REQ-018 state  out  3  FSM state (debug); illegal  out  1  one-cycle pulse; retired  out  16  retired-instruction count.

Function
REQ-019 States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 SHALL return to FETCH next cycle.
REQ-020 All outputs not listed for a state SHALL be 0; outputs Moore except REQ-021/027/030 ack-qualified strobes.
REQ-021 FETCH: mem_req=1, mem_addr_s=0, mem_we=0; on mem_ack=1 same cycle IR_write=1, PC_write=1, PC_s=00, next DECODE; else stay.
REQ-022 DECODE classes: R (000000), I1 (001xxx), LW (100011), SW (101011), BR (00010x), J (000010), JAL (000011); other opcodes -> illegal=1, next FETCH, no retire.
REQ-023 DECODE: J -> PC_write=1, PC_s=11, next FETCH; JAL -> additionally WriteReg=1, w_r_s=10, w_r_data_s=10; both retire; all others -> EXEC.
REQ-024 EXEC R: rt_imm_s=0; ALU_OP from funct: 100000 add, 100010 sub, 1001xx {0,funct[1:0]}, 101011 slt, 000100 sllv, else and(000); funct=001000 (jr) -> PC_write=1, PC_s=01, next FETCH, retire; otherwise next WB.
REQ-025 EXEC I1: rt_imm_s=1; addi(000) add imm_s=1; andi(100) and, ori(101) or, xori(110) xor, sltiu(011) slt, all imm_s=0; others and; next WB.
REQ-026 EXEC LW/SW: rt_imm_s=1, imm_s=1, ALU_OP=add, next MEM.
REQ-027 EXEC BR: rt_imm_s=0, imm_s=1, ALU_OP=sub; PC_write=ZF^opcode[0], PC_s=10; next FETCH, retire.
REQ-028 MEM: mem_req=1, mem_addr_s=1, rt_imm_s=1, imm_s=1, ALU_OP=add held; mem_we=1 for SW; on mem_ack SW -> FETCH (retire), LW -> WB; else stay.
REQ-029 WB: WriteReg=1 exactly one cycle; R: w_r_s=00, w_r_data_s=00, REQ-024 ALU_OP held; I1: w_r_s=01, w_r_data_s=00, REQ-025 controls held; LW: w_r_s=01, w_r_data_s=01; next FETCH, retire.
REQ-030 retired SHALL increment by 1 on the cycle the instruction leaves its last state; wraps FFFF->0000.
REQ-031 mem_ack when mem_req=0 SHALL be ignored; mem_ack held high SHALL not cause double strobes (state has advanced).
REQ-032 Class and opcode/funct-derived controls SHALL be latched in DECODE; later opcode/funct changes SHALL not affect EXEC/MEM/WB.

Reset
REQ-033 rst_n=0 SHALL asynchronously force state=FETCH, retired=0, illegal=0, and all strobes (mem_req, mem_we, IR_write, PC_write, WriteReg) to 0 within the reset assertion, including mid-MEM.
REQ-034 After rst_n rises, first edge SHALL begin FETCH with mem_req=1.

Verification
REQ-035 add (000000/100000), ack next cycle each access -> states 0,1,2,4,0; ALU_OP=100; WriteReg=1 only in WB, w_r_s=00; retired 0->1.
REQ-036 lw (100011), MEM ack delayed 3 cycles -> mem_req=1, mem_addr_s=1 held 4 cycles, then WB w_r_data_s=01, w_r_s=01; total 8 cycles.
REQ-037 beq (000100) ZF=1 -> EXEC PC_write=1, PC_s=10; bne (000101) ZF=1 -> PC_write=0; both return to FETCH.
REQ-038 jal (000011) -> DECODE PC_write=1, PC_s=11, WriteReg=1, w_r_s=10, w_r_data_s=10; next FETCH.
REQ-039 opcode 111111 -> illegal pulse 1 cycle in DECODE, retired unchanged; sw with rst_n=0 mid-MEM -> mem_req, mem_we drop to 0 immediately, state=0.
REQ-040 retired preset to FFFF via 65535 j instructions -> next retire gives 0000.
